// File: rtl/iob_eth_pkg.sv
// rtl/iob_eth_pkg.sv - shared MAC register map, descriptor bits and sequencer states
package iob_eth_pkg;

  localparam logic [11:0] MODER_OFF  = 12'h000;
  localparam logic [11:0] TX_BD0_OFF = 12'h400;
  localparam logic [11:0] TX_BD1_OFF = 12'h404;
  localparam logic [11:0] RX_BD0_OFF = 12'h600;
  localparam logic [11:0] RX_BD1_OFF = 12'h604;

  localparam int MODER_RXEN    = 0;
  localparam int MODER_TXEN    = 1;
  localparam int MODER_LOOPBCK = 7;
  localparam int MODER_FULLD   = 10;
  localparam logic [31:0] MODER_BASE = 32'h0000_A000;

  localparam int BD_RD  = 15;
  localparam int BD_E   = 15;
  localparam int BD_IRQ = 14;
  localparam int BD_WR  = 13;
  localparam int BD_PAD = 12;
  localparam int BD_CRC = 11;

  localparam logic [15:0] RX_BD_CTRL = (16'h1 << BD_E) | (16'h1 << BD_IRQ) | (16'h1 << BD_WR);
  localparam logic [15:0] TX_BD_CTRL = (16'h1 << BD_RD) | (16'h1 << BD_IRQ) | (16'h1 << BD_WR) |
                                       (16'h1 << BD_PAD) | (16'h1 << BD_CRC);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_POLL_TX = 3'd2,
    ST_POLL_RX = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } seq_state_t;

  function automatic logic [31:0] moder_word(input logic lb, input logic fd, input logic en);
    logic [31:0] w;
    w                = MODER_BASE;
    w[MODER_FULLD]   = fd;
    w[MODER_LOOPBCK] = lb;
    w[MODER_RXEN]    = en;
    w[MODER_TXEN]    = en;
    return w;
  endfunction

endpackage

// File: rtl/iob_eth_cfg_step.sv
// rtl/iob_eth_cfg_step.sv - configuration step index to MAC register write {address, wdata}
module iob_eth_cfg_step
  import iob_eth_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] TX_BUF_ADDR = 32'h0000_0000,
  parameter logic [31:0] RX_BUF_ADDR = 32'h0000_0080
) (
  input  logic [2:0]        i_step,
  input  logic [15:0]       i_tx_len,
  input  logic              i_loopback,
  input  logic              i_full_duplex,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_wdata
);

  always_comb begin
    o_address = ADDR_W'(MODER_OFF);
    o_wdata   = '0;
    case (i_step)
      3'd0: begin
        o_address = ADDR_W'(MODER_OFF);
        o_wdata   = DATA_W'(moder_word(i_loopback, i_full_duplex, 1'b0));
      end
      3'd1: begin
        o_address = ADDR_W'(RX_BD1_OFF);
        o_wdata   = DATA_W'(RX_BUF_ADDR);
      end
      3'd2: begin
        o_address = ADDR_W'(RX_BD0_OFF);
        o_wdata   = DATA_W'({16'h0000, RX_BD_CTRL});
      end
      3'd3: begin
        o_address = ADDR_W'(TX_BD1_OFF);
        o_wdata   = DATA_W'(TX_BUF_ADDR);
      end
      3'd4: begin
        o_address = ADDR_W'(TX_BD0_OFF);
        o_wdata   = DATA_W'({i_tx_len, TX_BD_CTRL});
      end
      3'd5: begin
        o_address = ADDR_W'(MODER_OFF);
        o_wdata   = DATA_W'(moder_word(i_loopback, i_full_duplex, 1'b1));
      end
      default: begin
        o_address = ADDR_W'(MODER_OFF);
        o_wdata   = '0;
      end
    endcase
  end

endmodule

// File: rtl/iob_eth_frame_seq.sv
// rtl/iob_eth_frame_seq.sv - programs MAC and descriptors, then polls TX/RX BDs to completion
module iob_eth_frame_seq
  import iob_eth_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] TX_BUF_ADDR = 32'h0000_0000,
  parameter logic [31:0] RX_BUF_ADDR = 32'h0000_0080,
  parameter int          POLL_GAP    = 16,
  parameter int          POLL_MAX    = 4096
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  start_i,
  input  logic [15:0]           tx_len_i,
  input  logic                  loopback_i,
  input  logic                  full_duplex_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           rx_len_o,
  output logic [7:0]            rx_status_o,
  output logic                  valid_o,
  output logic [ADDR_W-1:0]     address_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic                  ready_i
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  seq_state_t          r_state;
  logic [2:0]          r_step;
  logic [CNT_W-1:0]    r_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic                r_ret_rx;
  logic [15:0]         r_len;
  logic                r_lb;
  logic                r_fd;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [15:0]         r_rx_len;
  logic [7:0]          r_rx_status;

  logic [ADDR_W-1:0]   w_cfg_address;
  logic [DATA_W-1:0]   w_cfg_wdata;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_bd_owned;
  logic                w_unused;

  iob_eth_cfg_step #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TX_BUF_ADDR (TX_BUF_ADDR),
    .RX_BUF_ADDR (RX_BUF_ADDR)
  ) u_cfg_step (
    .i_step        (r_step),
    .i_tx_len      (r_len),
    .i_loopback    (r_lb),
    .i_full_duplex (r_fd),
    .o_address     (w_cfg_address),
    .o_wdata       (w_cfg_wdata)
  );

  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  // Bit 15 means "still owned by the MAC" in both descriptor kinds (RD for TX, E for RX).
  assign w_bd_owned = (r_state == ST_POLL_TX) ? rdata_i[BD_RD] : rdata_i[BD_E];
  assign w_unused   = &{1'b0, rdata_i[14:8]};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_ret_rx    <= 1'b0;
      r_len       <= '0;
      r_lb        <= 1'b0;
      r_fd        <= 1'b0;
      r_valid     <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_rx_len    <= '0;
      r_rx_status <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len   <= tx_len_i;
            r_lb    <= loopback_i;
            r_fd    <= full_duplex_i;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_step  <= '0;
            r_cnt   <= '0;
            r_state <= ST_CFG;
          end
        end
        ST_CFG: begin
          // Issuing only while valid is low guarantees an idle cycle between accesses.
          if (!r_valid) begin
            r_valid   <= 1'b1;
            r_address <= w_cfg_address;
            r_wdata   <= w_cfg_wdata;
            r_wstrb   <= '1;
          end else if (ready_i) begin
            r_valid <= 1'b0;
            if (r_step == 3'd5) r_state <= ST_POLL_TX;
            else                r_step  <= r_step + 3'd1;
          end
        end
        ST_POLL_TX, ST_POLL_RX: begin
          if (!r_valid) begin
            r_valid   <= 1'b1;
            r_address <= (r_state == ST_POLL_TX) ? ADDR_W'(TX_BD0_OFF) : ADDR_W'(RX_BD0_OFF);
            r_wdata   <= '0;
            r_wstrb   <= '0;
          end else if (ready_i) begin
            r_valid <= 1'b0;
            if (!w_bd_owned) begin
              if (r_state == ST_POLL_TX) begin
                r_cnt   <= '0;
                r_state <= ST_POLL_RX;
              end else begin
                r_rx_len    <= rdata_i[31:16];
                r_rx_status <= rdata_i[7:0];
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_state     <= ST_DONE;
              end
            end else begin
              r_cnt    <= w_cnt_next;
              r_ret_rx <= (r_state == ST_POLL_RX);
              r_gap    <= GAP_LOAD;
              r_state  <= (w_cnt_next == CNT_MAX) ? ST_ERR : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= r_ret_rx ? ST_POLL_RX : ST_POLL_TX;
          else             r_gap   <= r_gap - 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign error_o     = r_error;
  assign rx_len_o    = r_rx_len;
  assign rx_status_o = r_rx_status;
  assign valid_o     = r_valid;
  assign address_o   = r_address;
  assign wdata_o     = r_wdata;
  assign wstrb_o     = r_wstrb;

endmodule
